// File: rtl/mem_port_master.sv
// mem_port_master: shared I/D memory initiator, data beats fetch.
// Ports: clk, rst (sync, active-high); if_* fetch port; dm_* data port;
// mem_* to a 64x32 memory (comb read, sync write).
// Option: define MEMPORT_MISALIGN_CHECK_EN to trap misaligned LH/LW/SH/SW.
module mem_port_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_instr,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [2:0]  dm_funct3,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic [31:0] dm_rdata,
  output logic        dm_misaligned,
  output logic [5:0]  mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_function3,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {ACCESS, RMW_WR} state_t;

  state_t      state_q, state_d;
  logic        if_ready_q, if_ready_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        dm_ready_q, dm_ready_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        mis_q, mis_d;
  logic [31:0] merge_q, merge_d;
  logic [5:0]  waddr_q, waddr_d;

  logic        mis;
  logic        sub_st;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;
  logic [31:0] merged;
  logic        unused;

`ifdef MEMPORT_MISALIGN_CHECK_EN
  assign mis = ((dm_funct3 == 3'b001 ||
                 (!dm_we && dm_funct3 == 3'b101)) && dm_addr[0]) ||
               (dm_funct3 == 3'b010 && dm_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign unused = ^{if_addr[31:8], if_addr[1:0], dm_addr[31:8]};

  // SB = 000, SH = 001 need read-modify-write.
  assign sub_st = (dm_funct3[2:1] == 2'b00);

  always_comb begin
    ld_b = 8'(mem_rdata >> {dm_addr[1:0], 3'b000});
    ld_h = dm_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (dm_funct3)
      3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_ext = {24'h0, ld_b};
      3'b101:  ld_ext = {16'h0, ld_h};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (dm_funct3[0])
      merged[{dm_addr[1], 4'b0000} +: 16] = dm_wdata[15:0];
    else
      merged[{dm_addr[1:0], 3'b000} +: 8] = dm_wdata[7:0];
  end

  always_comb begin
    state_d    = state_q;
    if_ready_d = 1'b0;
    if_instr_d = if_instr_q;
    dm_ready_d = 1'b0;
    dm_rdata_d = dm_rdata_q;
    mis_d      = 1'b0;
    merge_d    = merge_q;
    waddr_d    = waddr_q;
    mem_addr   = if_addr[7:2];
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = dm_wdata;
    unique case (state_q)
      ACCESS: begin
        if (dm_req) begin
          mem_addr = dm_addr[7:2];
          if (mis) begin
            dm_ready_d = 1'b1;
            mis_d      = 1'b1;
            dm_rdata_d = 32'h0;
          end else if (!dm_we) begin
            mem_read   = 1'b1;
            dm_rdata_d = ld_ext;
            dm_ready_d = 1'b1;
          end else if (sub_st) begin
            mem_read = 1'b1;
            merge_d  = merged;
            waddr_d  = dm_addr[7:2];
            state_d  = RMW_WR;
          end else begin
            mem_write  = 1'b1;
            dm_ready_d = 1'b1;
          end
        end else if (if_req) begin
          mem_read   = 1'b1;
          if_instr_d = mem_rdata;
          if_ready_d = 1'b1;
        end
      end
      RMW_WR: begin
        mem_addr   = waddr_q;
        mem_write  = 1'b1;
        mem_wdata  = merge_q;
        dm_ready_d = 1'b1;
        state_d    = ACCESS;
      end
      default: state_d = ACCESS;
    endcase
    // No strobes leave the block while reset is held.
    if (rst) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCESS;
      if_ready_q <= 1'b0;
      if_instr_q <= 32'h0000_0013;
      dm_ready_q <= 1'b0;
      dm_rdata_q <= 32'h0;
      mis_q      <= 1'b0;
      merge_q    <= 32'h0;
      waddr_q    <= 6'h0;
    end else begin
      state_q    <= state_d;
      if_ready_q <= if_ready_d;
      if_instr_q <= if_instr_d;
      dm_ready_q <= dm_ready_d;
      dm_rdata_q <= dm_rdata_d;
      mis_q      <= mis_d;
      merge_q    <= merge_d;
      waddr_q    <= waddr_d;
    end
  end

  assign if_ready      = if_ready_q;
  assign if_instr      = if_instr_q;
  assign dm_ready      = dm_ready_q;
  assign dm_rdata      = dm_rdata_q;
  assign dm_misaligned = mis_q;
  assign mem_function3 = 3'b010;

endmodule

// File: doc/mem_port_master.md
# mem_port_master

Initiator side of the single shared instruction/data memory (64 × 32-bit words, combinational read, synchronous write). It arbitrates between the fetch stage and the memory stage for the one memory port, always giving data accesses priority. It performs sub-word stores as read-modify-write, sign- or zero-extends loads, and returns registered results with one-cycle ready pulses.

## Interface
- No parameters. Memory depth is fixed at 64 words and addressed by byte-address bits [7:2].
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_ready
- if_addr  in  32  fetch byte address
- if_ready  out  1  one-cycle pulse: if_instr valid
- if_instr  out  32  registered instruction
- dm_req  in  1  data request; held with the other dm_* inputs until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_funct3  in  3  RISC-V load/store funct3
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data, right-aligned
- dm_ready  out  1  one-cycle pulse: access complete
- dm_rdata  out  32  registered, extended load data
- dm_misaligned  out  1  pulses with dm_ready on a misaligned access
- mem_addr  out  6  word address
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_function3  out  3  constant 3'b010: memory always writes whole words
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  combinational read data from memory

## Operation
- States: ACCESS (default) and RMW_WR.
- ACCESS with dm_req=1 (data wins; fetch waits):
  - Load: mem_read=1, mem_addr=dm_addr[7:2]. The extended byte, half or word is registered into dm_rdata.
    - 000 LB, 001 LH: sign-extend.
    - 100 LBU, 101 LHU: zero-extend.
    - 010 and other codes: full word.
    - Lane selection uses dm_addr[1:0].
  - Store, funct3 = 010 or an undefined code: mem_write=1, mem_wdata=dm_wdata.
  - Store SB (000) or SH (001): mem_read=1. Register mem_rdata merged with the dm_wdata low byte or half at lane dm_addr[1:0] into a merge register. Go to RMW_WR.
- RMW_WR: mem_write=1, mem_wdata=merge register, mem_addr=registered word address. Return to ACCESS; fetch still waits.
- ACCESS with dm_req=0 and if_req=1: mem_read=1, mem_addr=if_addr[7:2]. Register mem_rdata into if_instr.
- Address bits [31:8] are ignored, so addresses wrap modulo 256 bytes.
- A request is re-sampled in the cycle its ready pulse is high. A requester that keeps req high presents a new access, which allows back-to-back throughput.

## Timing
- Reset values:
  - if_ready=0, dm_ready=0, dm_misaligned=0.
  - if_instr=32'h00000013 (NOP), dm_rdata=0.
  - State ACCESS, merge register 0.
  - mem_read and mem_write are forced to 0 while rst=1.
- Latency, for a request accepted in cycle N:
  - Fetch, load, SW: ready in N+1.
  - SB/SH: write in N+1, dm_ready in N+2.
- Fetch stall: if_ready stays low in every cycle that a data access, or its RMW_WR cycle, owns the port.
- Store-then-read: a write in cycle N is visible to any read in N+1 or later.
- rst asserted in RMW_WR: the write is suppressed, the state returns to ACCESS, and no ready pulse is issued.
- Both ready outputs are never high in the same cycle.

## Configuration
- MEMPORT_MISALIGN_CHECK_EN defined:
  - These accesses are misaligned: LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]≠0.
  - A misaligned access makes no memory access (mem_read=mem_write=0).
  - dm_ready and dm_misaligned pulse in N+1, and dm_rdata=0.
- MEMPORT_MISALIGN_CHECK_EN undefined:
  - dm_misaligned is tied to 0.
  - Halfword accesses use lane addr[1]×16; word accesses ignore addr[1:0].

## Test plan
- Reset: hold rst for 2 cycles → if_instr=32'h00000013, both ready outputs 0, no mem_write.
- Fetch: preload word 4 with 32'hDEADBEEF, if_req with if_addr=0x10 → if_ready in the next cycle with if_instr=32'hDEADBEEF.
- Contention: if_req and dm_req (LB, addr 0x13, word 4 = 32'h80FF_FF7F) in the same cycle → dm_ready first with dm_rdata=32'hFFFF_FF80, then if_ready one cycle later.
- SB RMW: word 2 = 32'h11223344, SB of 32'hAA at 0x09 → write in cycle N+1, dm_ready in N+2, word 2 = 32'h1122AA44, no if_ready during N..N+1.
- Reset in RMW_WR: SH issued, rst raised in its second cycle → memory word unchanged, no dm_ready.
- Misaligned (macro defined): LW at 0x06 → dm_ready and dm_misaligned in N+1, mem_read=0. With the macro undefined → word 1 is returned.
